// File: rtl/memblock_pkg.sv
`default_nettype none
// ============================================================================
// memblock_pkg: tbus widths, op codes and arbiter state encoding
// Rev 1.0
// ============================================================================
package memblock_pkg;

  localparam int RESULT_W      = 64;
  localparam int SRC_W         = 64;
  localparam int MASK_W        = 64;
  localparam int TBUS_OPTYPE_W = 2;

  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'd0;
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'd1;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_LD = 2'd1,
    ARB_BUSY_ST = 2'd2,
    ARB_DRAIN   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [RESULT_W-1:0]      index;
    logic [SRC_W-1:0]         wdata;
    logic [MASK_W-1:0]        wmask;
    logic [TBUS_OPTYPE_W-1:0] optype;
  } tbus_req_t;

endpackage : memblock_pkg
`default_nettype wire

// File: rtl/memblock_tbus_arb.sv
`default_nettype none
// ============================================================================
// memblock_tbus_arb: store-priority arbiter of load unit and store-queue tbus
// requests onto the single dcache tbus port, with load anti-starvation.
// Rev 1.0
// ============================================================================
module memblock_tbus_arb
  import memblock_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     ldu_tbus_index_valid,
  output logic                     ldu_tbus_index_ready,
  input  logic [RESULT_W-1:0]      ldu_tbus_index,
  input  logic [SRC_W-1:0]         ldu_tbus_write_data,
  input  logic [MASK_W-1:0]        ldu_tbus_write_mask,
  input  logic [TBUS_OPTYPE_W-1:0] ldu_tbus_operation_type,
  output logic [RESULT_W-1:0]      ldu_tbus_read_data,
  output logic                     ldu_tbus_operation_done,
  input  logic                     ldu_flush,
  input  logic                     stq_tbus_index_valid,
  output logic                     stq_tbus_index_ready,
  input  logic [RESULT_W-1:0]      stq_tbus_index,
  input  logic [SRC_W-1:0]         stq_tbus_write_data,
  input  logic [MASK_W-1:0]        stq_tbus_write_mask,
  input  logic [TBUS_OPTYPE_W-1:0] stq_tbus_operation_type,
  output logic                     stq_tbus_operation_done,
  output logic                     arb2dc_tbus_index_valid,
  input  logic                     arb2dc_tbus_index_ready,
  output logic [RESULT_W-1:0]      arb2dc_tbus_index,
  output logic [SRC_W-1:0]         arb2dc_tbus_write_data,
  output logic [MASK_W-1:0]        arb2dc_tbus_write_mask,
  output logic [TBUS_OPTYPE_W-1:0] arb2dc_tbus_operation_type,
  input  logic [RESULT_W-1:0]      arb2dc_tbus_read_data,
  input  logic                     arb2dc_tbus_operation_done
);

  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q;
  logic [STARVE_W-1:0] starve_cnt_q;
  logic [STARVE_W-1:0] starve_cnt_d;
  logic                active_q;

  logic      ld_req;
  logic      in_idle;
  logic      pick_st;
  logic      pick_ld;
  logic      st_fire;
  logic      ld_fire;
  logic      dc_done;
  tbus_req_t ld_pkt;
  tbus_req_t st_pkt;
  tbus_req_t win_pkt;

  assign ld_pkt = '{index:  ldu_tbus_index,
                    wdata:  ldu_tbus_write_data,
                    wmask:  ldu_tbus_write_mask,
                    optype: ldu_tbus_operation_type};
  assign st_pkt = '{index:  stq_tbus_index,
                    wdata:  stq_tbus_write_data,
                    wmask:  stq_tbus_write_mask,
                    optype: stq_tbus_operation_type};

  // active_q keeps every output at zero while reset is held, without a
  // combinational path from reset_n into the datapath.
  always_comb begin
    ld_req  = ldu_tbus_index_valid & ~ldu_flush;
    in_idle = active_q & (state_q == ARB_IDLE);
    pick_st = in_idle & stq_tbus_index_valid & (~ld_req | (starve_cnt_q < STARVE_MAX));
    pick_ld = in_idle & ld_req & ~pick_st;
    win_pkt = '0;
    if (pick_st) begin
      win_pkt = st_pkt;
    end else if (pick_ld) begin
      win_pkt = ld_pkt;
    end
  end

  assign arb2dc_tbus_index_valid    = pick_st | pick_ld;
  assign arb2dc_tbus_index          = win_pkt.index;
  assign arb2dc_tbus_write_data     = win_pkt.wdata;
  assign arb2dc_tbus_write_mask     = win_pkt.wmask;
  assign arb2dc_tbus_operation_type = win_pkt.optype;

  assign st_fire              = pick_st & arb2dc_tbus_index_ready;
  assign ld_fire              = pick_ld & arb2dc_tbus_index_ready;
  assign stq_tbus_index_ready = st_fire;
  assign ldu_tbus_index_ready = ld_fire;

  // A flush coincident with the load response swallows it.
  assign dc_done                 = arb2dc_tbus_operation_done;
  assign stq_tbus_operation_done = (state_q == ARB_BUSY_ST) & dc_done;
  assign ldu_tbus_operation_done = (state_q == ARB_BUSY_LD) & dc_done & ~ldu_flush;
  assign ldu_tbus_read_data      = active_q ? arb2dc_tbus_read_data : '0;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (st_fire) begin
      if (ld_req) begin
        starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX : starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end else if (ld_fire) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      active_q     <= 1'b0;
    end else begin
      active_q     <= 1'b1;
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        ARB_IDLE: begin
          if (st_fire) begin
            state_q <= ARB_BUSY_ST;
          end else if (ld_fire) begin
            state_q <= ARB_BUSY_LD;
          end
        end
        ARB_BUSY_ST: begin
          if (dc_done) begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_BUSY_LD: begin
          if (dc_done) begin
            state_q <= ARB_IDLE;
          end else if (ldu_flush) begin
            state_q <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (dc_done) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  spurious_done_in_idle: assert property (@(posedge clock) disable iff (!reset_n)
    !((state_q == ARB_IDLE) && arb2dc_tbus_operation_done))
    else $error("memblock_tbus_arb: tbus done with no transaction outstanding");
`endif

endmodule : memblock_tbus_arb
`default_nettype wire

// File: tb/tb_memblock_tbus_arb.sv
`default_nettype none
// ============================================================================
// tb_memblock_tbus_arb: randomized scoreboard bench for memblock_tbus_arb
// Rev 1.0
// ============================================================================
module tb_memblock_tbus_arb;
  import memblock_pkg::*;

  localparam int LIMIT = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                     reset_n;
  logic                     ldu_valid, ldu_ready, ldu_done, ldu_flush;
  logic [RESULT_W-1:0]      ldu_idx, ldu_rdata;
  logic [SRC_W-1:0]         ldu_wd;
  logic [MASK_W-1:0]        ldu_mask;
  logic [TBUS_OPTYPE_W-1:0] ldu_op;
  logic                     stq_valid, stq_ready, stq_done;
  logic [RESULT_W-1:0]      stq_idx;
  logic [SRC_W-1:0]         stq_wd;
  logic [MASK_W-1:0]        stq_mask;
  logic [TBUS_OPTYPE_W-1:0] stq_op;
  logic                     dc_valid, dc_ready, dc_done;
  logic [RESULT_W-1:0]      dc_idx, dc_rdata;
  logic [SRC_W-1:0]         dc_wd;
  logic [MASK_W-1:0]        dc_mask;
  logic [TBUS_OPTYPE_W-1:0] dc_op;

  memblock_tbus_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clock                      (clock),
    .reset_n                    (reset_n),
    .ldu_tbus_index_valid       (ldu_valid),
    .ldu_tbus_index_ready       (ldu_ready),
    .ldu_tbus_index             (ldu_idx),
    .ldu_tbus_write_data        (ldu_wd),
    .ldu_tbus_write_mask        (ldu_mask),
    .ldu_tbus_operation_type    (ldu_op),
    .ldu_tbus_read_data         (ldu_rdata),
    .ldu_tbus_operation_done    (ldu_done),
    .ldu_flush                  (ldu_flush),
    .stq_tbus_index_valid       (stq_valid),
    .stq_tbus_index_ready       (stq_ready),
    .stq_tbus_index             (stq_idx),
    .stq_tbus_write_data        (stq_wd),
    .stq_tbus_write_mask        (stq_mask),
    .stq_tbus_operation_type    (stq_op),
    .stq_tbus_operation_done    (stq_done),
    .arb2dc_tbus_index_valid    (dc_valid),
    .arb2dc_tbus_index_ready    (dc_ready),
    .arb2dc_tbus_index          (dc_idx),
    .arb2dc_tbus_write_data     (dc_wd),
    .arb2dc_tbus_write_mask     (dc_mask),
    .arb2dc_tbus_operation_type (dc_op),
    .arb2dc_tbus_read_data      (dc_rdata),
    .arb2dc_tbus_operation_done (dc_done)
  );

  typedef struct packed {
    logic                     st;
    logic [RESULT_W-1:0]      idx;
    logic [SRC_W-1:0]         wd;
    logic [MASK_W-1:0]        mask;
    logic [TBUS_OPTYPE_W-1:0] op;
  } grant_t;

  grant_t              req_q[$];
  logic [RESULT_W-1:0] ld_rsp_q[$];
  int                  st_rsp_q[$];
  int                  checks   = 0;
  int                  failures = 0;

  // Reference model: one transaction outstanding, its owner, whether the
  // owning load was flushed, and how many stores overtook a waiting load.
  bit m_busy, m_st, m_flushed, m_ld_req, m_win_st, m_win_ld;
  int m_starve;

  int p_ld, p_st, p_fl, p_rdy;
  bit quiet;
  bit dc_pend;
  int dc_lat;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctrl"}, {251'd0, dc_valid, ldu_ready, stq_ready, ldu_done, stq_done}, '0);
    check({name, "_payload"}, {dc_idx, dc_wd, dc_mask, dc_op}, '0);
    check({name, "_rdata"}, ldu_rdata, '0);
  endtask

  initial begin : ref_model
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        m_busy = 0; m_st = 0; m_flushed = 0; m_starve = 0;
      end else if (!m_busy) begin
        m_ld_req = ldu_valid && !ldu_flush;
        m_win_st = stq_valid && (!m_ld_req || m_starve < LIMIT);
        m_win_ld = m_ld_req && !m_win_st;
        if ((m_win_st || m_win_ld) && dc_ready) begin
          if (m_win_st) begin
            req_q.push_back('{st: 1'b1, idx: stq_idx, wd: stq_wd, mask: stq_mask, op: stq_op});
            m_starve = m_ld_req ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
          end else begin
            req_q.push_back('{st: 1'b0, idx: ldu_idx, wd: ldu_wd, mask: ldu_mask, op: ldu_op});
            m_starve = 0;
          end
          m_busy = 1; m_st = m_win_st; m_flushed = 0;
        end
      end else if (dc_done) begin
        if (m_st) st_rsp_q.push_back(1);
        else if (!m_flushed && !ldu_flush) ld_rsp_q.push_back(dc_rdata);
        m_busy = 0;
      end else if (!m_st && ldu_flush) begin
        m_flushed = 1;
      end
    end
  end

  initial begin : monitor
    grant_t              g;
    logic [RESULT_W-1:0] d;
    forever begin
      @(negedge clock);
      #1;
      if (reset_n) begin
        if (dc_valid && dc_ready) begin
          if (req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL grant_unexpected actual=fire idx=%0h required=no-fire", dc_idx);
          end else begin
            g = req_q.pop_front();
            check("grant", {58'd0, stq_ready, ldu_ready, dc_idx, dc_wd, dc_mask, dc_op},
                  {58'd0, g.st, ~g.st, g.idx, g.wd, g.mask, g.op});
          end
        end
        if (ldu_done) begin
          if (ld_rsp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL ldu_done_unexpected actual=1 required=0 data=%0h", ldu_rdata);
          end else begin
            d = ld_rsp_q.pop_front();
            check("ldu_read_data", ldu_rdata, d);
          end
        end
        if (stq_done) begin
          if (st_rsp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL stq_done_unexpected actual=1 required=0");
          end else begin
            void'(st_rsp_q.pop_front());
            checks++;
          end
        end
      end
    end
  end

  task automatic drive_cycle();
    bit ld_acc, st_acc, dc_fire;
    @(negedge clock);
    ld_acc  = ldu_valid && ldu_ready;
    st_acc  = stq_valid && stq_ready;
    dc_fire = dc_valid && dc_ready;
    @(posedge clock);
    #1;
    if (!ldu_valid || ld_acc) begin
      ldu_valid = !quiet && ($urandom % 100 < p_ld);
      ldu_idx   = {$urandom, $urandom};
      ldu_wd    = {$urandom, $urandom};
      ldu_mask  = {$urandom, $urandom};
      ldu_op    = TBUS_READ;
    end
    if (!stq_valid || st_acc) begin
      stq_valid = !quiet && ($urandom % 100 < p_st);
      stq_idx   = {$urandom, $urandom};
      stq_wd    = {$urandom, $urandom};
      stq_mask  = {$urandom, $urandom};
      stq_op    = TBUS_WRITE;
    end
    ldu_flush = !quiet && ($urandom % 100 < p_fl);
    dc_ready  = ($urandom % 100 < p_rdy);
    if (dc_fire) begin
      dc_pend = 1;
      dc_lat  = $urandom_range(0, 3);
    end
    dc_done  = 1'b0;
    dc_rdata = {$urandom, $urandom};
    if (dc_pend) begin
      if (dc_lat == 0) begin
        dc_done = 1'b1;
        dc_pend = 0;
      end else begin
        dc_lat--;
      end
    end
  endtask

  task automatic run_phase(input int pl, input int ps, input int pf, input int pr, input int n);
    p_ld = pl; p_st = ps; p_fl = pf; p_rdy = pr;
    repeat (n) drive_cycle();
  endtask

  task automatic release_reset();
    ldu_valid = 0; stq_valid = 0; ldu_flush = 0; dc_done = 0; dc_pend = 0;
    @(posedge clock);
    #1;
    reset_n = 1;
    quiet   = 1;
    repeat (2) drive_cycle();
    quiet = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    reset_n   = 0;
    quiet     = 0;
    dc_pend   = 0;
    dc_lat    = 0;
    ldu_valid = 1; ldu_idx = 64'h8000_0010; ldu_wd = '1; ldu_mask = '1; ldu_op = TBUS_READ;
    stq_valid = 1; stq_idx = 64'h8000_0020; stq_wd = '1; stq_mask = '1; stq_op = TBUS_WRITE;
    ldu_flush = 0; dc_ready = 1; dc_done = 1; dc_rdata = 64'hDEAD;
    repeat (3) @(posedge clock);
    #2;
    check_outputs_zero("reset_hold");
    release_reset();

    run_phase(60, 30, 0, 70, 300);
    run_phase(80, 95, 0, 90, 400);

    n = 0;
    while (!(m_busy && m_st) && n < 500) begin
      drive_cycle();
      n++;
    end
    if (!(m_busy && m_st)) begin
      checks++; failures++;
      $display("FAIL wait_store_busy actual=not-busy required=busy-store");
    end else begin
      reset_n = 0;
      dc_done = 0;
      dc_pend = 0;
      #1;
      check_outputs_zero("reset_mid_store");
      req_q.delete(); ld_rsp_q.delete(); st_rsp_q.delete();
      repeat (2) @(posedge clock);
      release_reset();
    end

    run_phase(70, 40, 25, 70, 400);
    run_phase(60, 60, 5, 20, 300);
    run_phase(0, 0, 0, 100, 80);

    check("final_grants_pending", req_q.size(), 0);
    check("final_ld_rsp_pending", ld_rsp_q.size(), 0);
    check("final_st_rsp_pending", st_rsp_q.size(), 0);
    check("final_idle_valid", {255'd0, dc_valid}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_memblock_tbus_arb
`default_nettype wire
